// File: rtl/cs_pkg.sv
// rtl/cs_pkg.sv - shared defaults, width helpers and mode encoding for the CS smoothing filter
package cs_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 9;
    localparam int DEF_SHIFT = 3;

    localparam logic MODE_BELOW = 1'b0;
    localparam logic MODE_ABOVE = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int sum_w(input int dw, input int depth);
        return dw + clog2(depth + 1);
    endfunction

    function automatic int y_w(input int dw, input int depth, input int shift);
        return dw + clog2(2 * depth) - shift;
    endfunction

endpackage

// File: rtl/cs_filter_gen_select.sv
// rtl/cs_filter_gen_select.sv - division-free mean test plus log-depth max/min tree picking Xappr
module cs_select
    import cs_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SW    = sum_w(DW, DEPTH)
) (
    input  logic [DEPTH*DW-1:0] window,
    input  logic [SW-1:0]       sum,
    input  logic                mode,
    output logic [DW-1:0]       xappr
);

    localparam int LG = clog2(DEPTH);
    localparam int P  = 1 << LG;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    logic [DW-1:0] neutral;
    logic [DW-1:0] lvl [P];

    function automatic logic [DW-1:0] pick(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic m);
        if (m == MODE_ABOVE) begin
            return (a < b) ? a : b;
        end
        return (a > b) ? a : b;
    endfunction

    // Non-candidates become the reduction's identity so they can never win.
    assign neutral = (mode == MODE_ABOVE) ? '1 : '0;

    always_comb begin
        for (int i = 0; i < P; i++) begin
            lvl[i] = neutral;
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] xi;
            logic [SW-1:0] scaled;
            logic          cand;
            xi     = window[i*DW +: DW];
            scaled = SW'(xi) * DEPTH_S;
            cand   = (mode == MODE_ABOVE) ? (scaled >= sum) : (scaled <= sum);
            lvl[i] = cand ? xi : neutral;
        end
        for (int l = 0; l < LG; l++) begin
            for (int i = 0; i < (P >> (l + 1)); i++) begin
                lvl[i] = pick(lvl[2*i], lvl[2*i+1], mode);
            end
        end
    end

    assign xappr = lvl[0];

endmodule

// File: rtl/cs_filter_gen.sv
// rtl/cs_filter_gen.sv - sliding-window CS smoothing filter with valid qualifiers, clear and mode
module cs_filter_gen
    import cs_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SHIFT = DEF_SHIFT,
    parameter int SW    = sum_w(DW, DEPTH),
    parameter int YW    = y_w(DW, DEPTH, SHIFT),
    parameter int FW    = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic          mode,
    input  logic [DW-1:0] X,
    output logic [YW-1:0] Y,
    output logic          out_valid,
    output logic [FW-1:0] fill
);

    localparam logic [FW-1:0] FULL    = FW'(DEPTH);
    localparam logic [SW:0]   DEPTH_A = (SW + 1)'(DEPTH);

    logic [DEPTH*DW-1:0] win_q, win_d;
    logic [SW-1:0]       sum_q, sum_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [YW-1:0]       y_q, y_d;
    logic                valid_q, valid_d;

    logic [DW-1:0] oldest;
    logic [DW-1:0] xappr;
    logic [SW:0]   acc;

    assign oldest = win_q[DEPTH*DW-1 -: DW];

    // Selection sees the window after this cycle's accept, so Y lands on the accepting edge.
    cs_select #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .SW    (SW)
    ) u_select (
        .window (win_d),
        .sum    (sum_d),
        .mode   (mode),
        .xappr  (xappr)
    );

    assign acc = {1'b0, sum_d} + (SW + 1)'(xappr) * DEPTH_A;

    always_comb begin
        win_d   = win_q;
        sum_d   = sum_q;
        fill_d  = fill_q;
        y_d     = y_q;
        valid_d = 1'b0;
        if (clear) begin
            win_d  = '0;
            sum_d  = '0;
            fill_d = '0;
            if (in_valid) begin
                win_d[DW-1:0] = X;
                sum_d         = SW'(X);
                fill_d        = FW'(1);
            end
        end else if (in_valid) begin
            win_d = {win_q[(DEPTH-1)*DW-1:0], X};
            if (fill_q == FULL) begin
                sum_d  = sum_q + SW'(X) - SW'(oldest);
                fill_d = fill_q;
            end else begin
                sum_d  = sum_q + SW'(X);
                fill_d = fill_q + FW'(1);
            end
            y_d     = YW'(acc >> SHIFT);
            valid_d = (fill_d == FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            win_q   <= '0;
            sum_q   <= '0;
            fill_q  <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            sum_q   <= sum_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign Y         = y_q;
    assign out_valid = valid_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_cs_filter_gen.sv
// tb/tb_cs_filter_gen.sv - randomized and directed self-checking bench for cs_filter_gen
module tb_cs_filter_gen;
    import cs_pkg::*;

    localparam int DA = 9;
    localparam int SA = 3;
    localparam int DB = 16;
    localparam int SB = 4;
    localparam int YWA = y_w(8, DA, SA);
    localparam int YWB = y_w(8, DB, SB);
    localparam int FWA = clog2(DA + 1);
    localparam int FWB = clog2(DB + 1);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] x = '0;

    logic [YWA-1:0] y_a;
    logic           v_a;
    logic [FWA-1:0] f_a;
    logic [YWB-1:0] y_b;
    logic           v_b;
    logic [FWB-1:0] f_b;

    int  checks = 0;
    int  errors = 0;
    bit  cmp_en = 1'b0;
    int  hist[$];
    int  ey_a = 0, ey_b = 0;
    bit  ev_a = 1'b0, ev_b = 1'b0;

    always #5 clk = ~clk;

    cs_filter_gen #(.DW(8), .DEPTH(DA), .SHIFT(SA)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .mode(mode), .X(x),
        .Y(y_a), .out_valid(v_a), .fill(f_a)
    );

    cs_filter_gen #(.DW(8), .DEPTH(DB), .SHIFT(SB)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .mode(mode), .X(x),
        .Y(y_b), .out_valid(v_b), .fill(f_b)
    );

    // Reference: last d accepted samples, zero-padded, mean test and selection by brute force.
    function automatic int model_y(input int q[$], input int d, input int sh, input bit m);
        int vals[$];
        int n, lo, s, best;
        n  = q.size();
        lo = (n > d) ? n - d : 0;
        for (int i = lo; i < n; i++) vals.push_back(q[i]);
        while (vals.size() < d) vals.push_back(0);
        s = 0;
        foreach (vals[i]) s += vals[i];
        best = m ? (1 << 30) : -1;
        foreach (vals[i]) begin
            if (m) begin
                if (vals[i] * d >= s && vals[i] < best) best = vals[i];
            end else begin
                if (vals[i] * d <= s && vals[i] > best) best = vals[i];
            end
        end
        return (s + d * best) >> sh;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            hist.delete();
            ey_a = 0; ey_b = 0; ev_a = 0; ev_b = 0;
        end else if (clear) begin
            hist.delete();
            if (in_valid) hist.push_back(int'(x));
            ev_a = 0; ev_b = 0;
        end else if (in_valid) begin
            hist.push_back(int'(x));
            if (hist.size() > 64) void'(hist.pop_front());
            ey_a = model_y(hist, DA, SA, mode);
            ey_b = model_y(hist, DB, SB, mode);
            ev_a = (hist.size() >= DA);
            ev_b = (hist.size() >= DB);
        end else begin
            ev_a = 0; ev_b = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("y_a", int'(y_a), ey_a);
            chk("valid_a", int'(v_a), int'(ev_a));
            chk("fill_a", int'(f_a), min_i(hist.size(), DA));
            chk("y_b", int'(y_b), ey_b);
            chk("valid_b", int'(v_b), int'(ev_b));
            chk("fill_b", int'(f_b), min_i(hist.size(), DB));
        end
    end

    task automatic step(input bit v, input int xv, input bit m, input bit clr);
        in_valid = v;
        x        = 8'(xv);
        mode     = m;
        clear    = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(0, 0, 0, 0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        cmp_en = 1'b1;
        chk("rst_y", int'(y_a), 0);
        chk("rst_valid", int'(v_a), 0);
        chk("rst_fill", int'(f_a), 0);
        reset = 1'b1;

        for (int i = 1; i <= 9; i++) begin
            step(1, i, 0, 0);
            if (i < 9) chk("ramp_early_valid", int'(v_a), 0);
        end
        chk("ramp_valid", int'(v_a), 1);
        chk("ramp_y", int'(y_a), 11);
        chk("ramp_model", ey_a, 11);

        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        step(1, 9, 0, 0);
        chk("spike_below_y", int'(y_a), 1);
        chk("spike_below_model", ey_a, 1);

        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0);
        step(1, 9, 1, 0);
        chk("spike_above_y", int'(y_a), 11);
        chk("spike_above_model", ey_a, 11);

        do_reset();
        for (int i = 0; i < 9; i++) step(1, 255, 0, 0);
        chk("sat_y", int'(y_a), 573);
        step(1, 0, 0, 0);
        chk("sat_drop_y", int'(y_a), 255);
        chk("sat_drop_model", ey_a, 255);

        for (int i = 0; i < 5; i++) begin
            step(0, $urandom_range(255), 1, 0);
            chk("gap_hold_y", int'(y_a), 255);
            chk("gap_valid", int'(v_a), 0);
        end
        step(1, 37, 0, 0);
        chk("resume_valid", int'(v_a), 1);

        for (int i = 0; i < 12; i++) step(1, $urandom_range(255), 0, 0);
        step(1, 100, 0, 1);
        chk("clear_fill", int'(f_a), 1);
        chk("clear_valid", int'(v_a), 0);
        for (int i = 0; i < 7; i++) begin
            step(1, $urandom_range(255), 1, 0);
            chk("refill_valid", int'(v_a), 0);
        end
        step(1, 50, 0, 0);
        chk("refill_done", int'(v_a), 1);

        reset = 1'b0;
        step(1, 77, 0, 0);
        chk("midrst_y", int'(y_a), 0);
        chk("midrst_valid", int'(v_a), 0);
        chk("midrst_fill", int'(f_a), 0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step(1, $urandom_range(255), 0, 0);
        chk("midrst_refill", int'(v_a), 0);
        step(1, 5, 0, 0);
        chk("midrst_refilled", int'(v_a), 1);

        for (int i = 0; i < 2000; i++) begin
            int xv;
            case ($urandom_range(3))
                0: xv = 0;
                1: xv = 255;
                default: xv = $urandom_range(255);
            endcase
            reset = ($urandom_range(699) != 0);
            step($urandom_range(3) != 0, xv, 1'($urandom_range(1)), $urandom_range(96) == 0);
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
